// File: rtl/data_array_if.sv
// Port bundle for one cache-way data array: full-line read port, byte-enabled
// store port and the critical-bank-first refill beat stream.
interface data_array_if #(
   parameter int SETS   = 256,
   parameter int BANKS  = 4,
   parameter int BANK_W = 32
);
   localparam int IDX_W  = $clog2(SETS);
   localparam int BE_W   = BANK_W / 8;
   localparam int BK_W   = $clog2(BANKS);
   localparam int OFF_W  = BK_W + $clog2(BE_W);
   localparam int LINE_W = BANKS * BANK_W;

   logic              rd_en_i;
   logic [IDX_W-1:0]  rd_index_i;
   logic [LINE_W-1:0] rd_data_o;
   logic              rd_valid_o;

   logic              st_en_i;
   logic [IDX_W-1:0]  st_index_i;
   logic [OFF_W-1:0]  st_offset_i;
   logic [BE_W-1:0]   st_be_i;
   logic [BANK_W-1:0] st_data_i;
   logic              st_ready_o;

   logic              rf_start_i;
   logic [IDX_W-1:0]  rf_index_i;
   logic [BK_W-1:0]   rf_crit_i;
   logic              rf_valid_i;
   logic [BANK_W-1:0] rf_data_i;
   logic              rf_ready_o;
   logic              rf_done_o;
   logic              busy_o;

   modport master (
      output rd_en_i, rd_index_i,
      input  rd_data_o, rd_valid_o,
      output st_en_i, st_index_i, st_offset_i, st_be_i, st_data_i,
      input  st_ready_o,
      output rf_start_i, rf_index_i, rf_crit_i, rf_valid_i, rf_data_i,
      input  rf_ready_o, rf_done_o, busy_o
   );

   modport slave (
      input  rd_en_i, rd_index_i,
      output rd_data_o, rd_valid_o,
      input  st_en_i, st_index_i, st_offset_i, st_be_i, st_data_i,
      output st_ready_o,
      input  rf_start_i, rf_index_i, rf_crit_i, rf_valid_i, rf_data_i,
      output rf_ready_o, rf_done_o, busy_o
   );
endinterface

// File: rtl/data_array.sv
// Cache-way data array: per-bank byte-writable storage, registered full-line
// read with write-first byte-merged forwarding, and a wrapping refill engine.
module data_array #(
   parameter int SETS   = 256,
   parameter int BANKS  = 4,
   parameter int BANK_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   data_array_if.slave  bus
);
   localparam int IDX_W  = $clog2(SETS);
   localparam int BE_W   = BANK_W / 8;
   localparam int BK_W   = $clog2(BANKS);
   localparam int BOFF_W = $clog2(BE_W);
   localparam int OFF_W  = BK_W + BOFF_W;
   localparam int LINE_W = BANKS * BANK_W;
   localparam int CNT_W  = BK_W + 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] REFILL = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  rf_index_q, rf_index_d;
   logic [BK_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [LINE_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q;

   logic              st_fire;
   logic              beat_fire;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_index;
   logic [BK_W-1:0]   wr_bank;
   logic [BE_W-1:0]   wr_be;
   logic [BANK_W-1:0] wr_data;
   logic              unused_offset_bits;

   logic [BANK_W-1:0] mem_q [BANKS][SETS];

   assign unused_offset_bits = ^bus.st_offset_i;

   // Store and refill beat are mutually exclusive by state, so one write port suffices.
   always_comb begin
      st_fire   = bus.st_en_i && (state_q == IDLE);
      beat_fire = bus.rf_valid_i && (state_q == REFILL);
      wr_en     = st_fire || beat_fire;
      if (beat_fire) begin
         wr_index = rf_index_q;
         wr_bank  = ptr_q;
         wr_be    = {BE_W{1'b1}};
         wr_data  = bus.rf_data_i;
      end else begin
         wr_index = bus.st_index_i;
         wr_bank  = bus.st_offset_i[OFF_W-1:BOFF_W];
         wr_be    = bus.st_be_i;
         wr_data  = bus.st_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < BE_W; k++) begin
            if (wr_be[k]) begin
               mem_q[wr_bank][wr_index][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
         end
      end
   end

   // Byte-merged forwarding: bytes written this cycle override the array contents.
   always_comb begin
      rd_data_d = {LINE_W{1'b0}};
      for (int b = 0; b < BANKS; b++) begin
         for (int k = 0; k < BE_W; k++) begin
            if (wr_en && (wr_bank == BK_W'(b)) && (wr_index == bus.rd_index_i) && wr_be[k]) begin
               rd_data_d[b*BANK_W + k*8 +: 8] = wr_data[k*8 +: 8];
            end else begin
               rd_data_d[b*BANK_W + k*8 +: 8] = mem_q[b][bus.rd_index_i][k*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rf_index_d = rf_index_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rf_start_i) begin
               state_d    = REFILL;
               rf_index_d = bus.rf_index_i;
               ptr_d      = bus.rf_crit_i;
               cnt_d      = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         REFILL: begin
            if (bus.rf_valid_i) begin
               ptr_d = ptr_q + BK_W'(1);
               cnt_d = cnt_q + CNT_W'(1);
               // The BANKS-th accepted beat closes the refill.
               if (cnt_q == CNT_W'(BANKS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = REFILL;
               end
            end else begin
               state_d = REFILL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rf_index_q <= {IDX_W{1'b0}};
         ptr_q      <= {BK_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         done_q     <= 1'b0;
         rd_data_q  <= {LINE_W{1'b0}};
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rf_index_q <= rf_index_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         rd_valid_q <= bus.rd_en_i;
         if (bus.rd_en_i) begin
            rd_data_q <= rd_data_d;
         end else begin
            rd_data_q <= rd_data_q;
         end
      end
   end

   assign bus.rd_data_o  = rd_data_q;
   assign bus.rd_valid_o = rd_valid_q;
   assign bus.rf_done_o  = done_q;
   assign bus.busy_o     = (state_q == REFILL);
   assign bus.rf_ready_o = (state_q == REFILL);
   assign bus.st_ready_o = (state_q == IDLE);
endmodule

// File: tb/tb_data_array.sv
// Self-checking bench for data_array: reference model with a read scoreboard,
// plus directed scenarios for forwarding, wrapped/gapped refill and reset.
module tb_data_array;
   localparam int SETS   = 256;
   localparam int BANKS  = 4;
   localparam int BANK_W = 32;
   localparam int LINE_W = BANKS * BANK_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   data_array_if #(.SETS(SETS), .BANKS(BANKS), .BANK_W(BANK_W)) bus ();
   data_array #(.SETS(SETS), .BANKS(BANKS), .BANK_W(BANK_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [LINE_W-1:0] d;
      logic [LINE_W-1:0] m;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_mem   [SETS][BANKS];
   logic [3:0]  m_known [SETS][BANKS];
   logic        m_busy   = 1'b0;
   logic        m_was    = 1'b0;
   logic [1:0]  m_ptr    = 2'd0;
   int          m_cnt    = 0;
   int          m_b      = 0;
   logic [7:0]  m_idx    = 8'd0;
   logic        exp_rv   = 1'b0;
   logic        exp_done = 1'b0;
   exp_t        m_e;
   exp_t        c_e;
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [LINE_W-1:0] line;

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int s = 0; s < SETS; s++) begin
         for (int b = 0; b < BANKS; b++) begin
            m_mem[s][b]   = 32'h0;
            m_known[s][b] = 4'h0;
         end
      end
   end

   // Reference model: applies the accepted write first, then snapshots reads.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy   = 1'b0;
         m_ptr    = 2'd0;
         m_cnt    = 0;
         exp_rv   = 1'b0;
         exp_done = 1'b0;
         sb_q.delete();
      end else begin
         m_was    = m_busy;
         exp_done = 1'b0;
         if (!m_was && bus.st_en_i) begin
            m_b = int'(bus.st_offset_i[3:2]);
            for (int k = 0; k < 4; k++) begin
               if (bus.st_be_i[k]) begin
                  m_mem[bus.st_index_i][m_b][k*8 +: 8] = bus.st_data_i[k*8 +: 8];
                  m_known[bus.st_index_i][m_b][k]     = 1'b1;
               end
            end
         end
         if (m_was && bus.rf_valid_i) begin
            m_mem[m_idx][m_ptr]   = bus.rf_data_i;
            m_known[m_idx][m_ptr] = 4'hF;
            m_ptr = m_ptr + 2'd1;
            m_cnt = m_cnt + 1;
            if (m_cnt == BANKS) begin
               m_busy   = 1'b0;
               exp_done = 1'b1;
            end
         end
         if (!m_was && bus.rf_start_i) begin
            m_busy = 1'b1;
            m_idx  = bus.rf_index_i;
            m_ptr  = bus.rf_crit_i;
            m_cnt  = 0;
         end
         exp_rv = bus.rd_en_i;
         if (bus.rd_en_i) begin
            for (int b = 0; b < BANKS; b++) begin
               for (int k = 0; k < 4; k++) begin
                  m_e.d[b*32 + k*8 +: 8] = m_mem[bus.rd_index_i][b][k*8 +: 8];
                  m_e.m[b*32 + k*8 +: 8] = {8{m_known[bus.rd_index_i][b][k]}};
               end
            end
            sb_q.push_back(m_e);
         end
      end
   end

   // Per-cycle output comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("busy", {127'd0, bus.busy_o}, {127'd0, m_busy});
      check("rf_ready", {127'd0, bus.rf_ready_o}, {127'd0, m_busy});
      check("st_ready", {127'd0, bus.st_ready_o}, {127'd0, ~m_busy});
      check("rf_done", {127'd0, bus.rf_done_o}, {127'd0, exp_done});
      check("rd_valid", {127'd0, bus.rd_valid_o}, {127'd0, exp_rv});
      if (exp_rv) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", {127'd0, 1'b1}, {127'd0, 1'b0});
         end else begin
            c_e = sb_q.pop_front();
            check("rd_data", bus.rd_data_o & c_e.m, c_e.d & c_e.m);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.rd_en_i = 1'b0; bus.rd_index_i = 8'd0;
      bus.st_en_i = 1'b0; bus.st_index_i = 8'd0; bus.st_offset_i = 4'd0;
      bus.st_be_i = 4'd0; bus.st_data_i = 32'd0;
      bus.rf_start_i = 1'b0; bus.rf_index_i = 8'd0; bus.rf_crit_i = 2'd0;
      bus.rf_valid_i = 1'b0; bus.rf_data_i = 32'd0;
   endtask

   task automatic store(input logic [7:0] idx, input logic [3:0] off, input logic [3:0] be, input logic [31:0] d);
      bus.st_en_i = 1'b1; bus.st_index_i = idx; bus.st_offset_i = off;
      bus.st_be_i = be; bus.st_data_i = d;
      tick();
      bus.st_en_i = 1'b0;
   endtask

   task automatic read_line(input logic [7:0] idx, output logic [LINE_W-1:0] l);
      bus.rd_en_i = 1'b1; bus.rd_index_i = idx;
      tick();
      bus.rd_en_i = 1'b0;
      l = bus.rd_data_o;
   endtask

   task automatic start(input logic [7:0] idx, input logic [1:0] crit);
      bus.rf_start_i = 1'b1; bus.rf_index_i = idx; bus.rf_crit_i = crit;
      tick();
      bus.rf_start_i = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      bus.rf_valid_i = 1'b1; bus.rf_data_i = d;
      tick();
      bus.rf_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      check("rst_rd_data", bus.rd_data_o, 128'd0);
      check("rst_rd_valid", {127'd0, bus.rd_valid_o}, 128'd0);
      check("rst_st_ready", {127'd0, bus.st_ready_o}, 128'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Full-bank store then read back bank 2.
      store(8'd5, 4'h8, 4'b1111, 32'hDEADBEEF);
      read_line(8'd5, line);
      check("t1_bank2", {96'd0, line[95:64]}, {96'd0, 32'hDEADBEEF});
      check("t1_valid", {127'd0, bus.rd_valid_o}, 128'd1);
      tick();
      check("t1_valid_pulse", {127'd0, bus.rd_valid_o}, 128'd0);

      // Partial store forwarded into a same-cycle read.
      store(8'd7, 4'h0, 4'b1111, 32'h11223344);
      bus.rd_en_i = 1'b1; bus.rd_index_i = 8'd7;
      store(8'd7, 4'h0, 4'b0101, 32'hAABBCCDD);
      bus.rd_en_i = 1'b0;
      check("t2_fwd_bank0", {96'd0, bus.rd_data_o[31:0]}, {96'd0, 32'h11BB33DD});
      read_line(8'd7, line);
      check("t2_array_bank0", {96'd0, line[31:0]}, {96'd0, 32'h11BB33DD});

      // Wrapped refill from bank 2; stores attempted while busy are dropped.
      start(8'd9, 2'd2);
      check("t3_ready", {127'd0, bus.rf_ready_o}, 128'd1);
      bus.st_en_i = 1'b1; bus.st_index_i = 8'd9; bus.st_offset_i = 4'h0;
      bus.st_be_i = 4'hF; bus.st_data_i = 32'hFFFFFFFF;
      beat(32'hA0000001);
      beat(32'hB0000002);
      beat(32'hC0000003);
      bus.st_en_i = 1'b0;
      check("t3_no_early_done", {127'd0, bus.rf_done_o}, 128'd0);
      beat(32'hD0000004);
      check("t3_done", {127'd0, bus.rf_done_o}, 128'd1);
      read_line(8'd9, line);
      check("t3_line", line, {32'hB0000002, 32'hA0000001, 32'hD0000004, 32'hC0000003});
      check("t3_done_pulse", {127'd0, bus.rf_done_o}, 128'd0);

      // Refill with a three-cycle gap; last beat forwarded into a read.
      start(8'd10, 2'd1);
      beat(32'hE0000005);
      for (int g = 0; g < 3; g++) begin
         tick();
         check("t4_gap_busy", {127'd0, bus.busy_o}, 128'd1);
      end
      beat(32'hF0000006);
      beat(32'h07000007);
      check("t4_no_early_done", {127'd0, bus.rf_done_o}, 128'd0);
      bus.rd_en_i = 1'b1; bus.rd_index_i = 8'd10;
      beat(32'h08000008);
      bus.rd_en_i = 1'b0;
      check("t4_done", {127'd0, bus.rf_done_o}, 128'd1);
      check("t4_line_fwd", bus.rd_data_o, {32'h07000007, 32'hF0000006, 32'hE0000005, 32'h08000008});

      // Reset in the middle of a refill of a preloaded line.
      for (int b = 0; b < BANKS; b++) begin
         store(8'd3, 4'(b * 4), 4'hF, 32'h55550000 + 32'(b));
      end
      start(8'd3, 2'd0);
      beat(32'h31313131);
      beat(32'h32323232);
      bus.rf_valid_i = 1'b1; bus.rf_data_i = 32'h33333333;
      rst_n = 1'b0;
      #1;
      check("t5_idle_now", {127'd0, bus.busy_o}, 128'd0);
      check("t5_rd_data_rst", bus.rd_data_o, 128'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      bus.rf_valid_i = 1'b0;
      check("t5_still_idle", {127'd0, bus.busy_o}, 128'd0);
      read_line(8'd3, line);
      check("t5_line", line, {32'h55550003, 32'h55550002, 32'h32323232, 32'h31313131});
      start(8'd3, 2'd0);
      beat(32'h41414141);
      beat(32'h42424242);
      beat(32'h43434343);
      beat(32'h44444444);
      check("t5_new_done", {127'd0, bus.rf_done_o}, 128'd1);
      read_line(8'd3, line);
      check("t5_new_line", line, {32'h44444444, 32'h43434343, 32'h42424242, 32'h41414141});

      // Store and refill start in the same idle cycle.
      bus.rf_start_i = 1'b1; bus.rf_index_i = 8'd21; bus.rf_crit_i = 2'd3;
      store(8'd20, 4'h4, 4'hF, 32'h12345678);
      bus.rf_start_i = 1'b0;
      check("t6_busy", {127'd0, bus.busy_o}, 128'd1);
      beat(32'h51515151);
      beat(32'h52525252);
      beat(32'h53535353);
      beat(32'h54545454);
      read_line(8'd20, line);
      check("t6_store_landed", {96'd0, line[63:32]}, {96'd0, 32'h12345678});
      read_line(8'd21, line);
      check("t6_refill_line", line, {32'h51515151, 32'h54545454, 32'h53535353, 32'h52525252});
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
